// File: rtl/vga_line_prefetcher.sv
// Ping-pong scanline prefetcher for the VGA output path.
// While one line buffer is displayed, the next visible line is read from the
// front frame buffer into the other one over a request/acknowledge port.
// Line y always lives in line_buf[y[0]], so display and fetch never collide.
module vga_line_prefetcher #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525,
    parameter int ADDR_W   = 20,
    parameter int FB0_BASE = 0,
    parameter int FB1_BASE = 307200
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [9:0]        DRAW_X,
    input  logic [9:0]        DRAW_Y,
    input  logic              VGA_VS,
    input  logic              FB_SEL,
    input  logic              CLR_UNDERRUN,
    output logic              MEM_REQ,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic              MEM_ACK,
    input  logic [23:0]       MEM_RDATA,
    output logic [7:0]        PIX_R,
    output logic [7:0]        PIX_G,
    output logic [7:0]        PIX_B,
    output logic              FRONT_BUF,
    output logic              LINE_DONE,
    output logic              UNDERRUN
);

    localparam int                XW         = $clog2(H_ACTIVE);
    localparam logic [9:0]        H_ACT_10   = 10'(H_ACTIVE);
    localparam logic [9:0]        V_ACT_10   = 10'(V_ACTIVE);
    localparam logic [9:0]        V_LAST_10  = 10'(V_TOTAL - 1);
    localparam logic [XW-1:0]     X_LAST     = XW'(H_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] BASE0      = ADDR_W'(FB0_BASE);
    localparam logic [ADDR_W-1:0] BASE1      = ADDR_W'(FB1_BASE);
    localparam logic [ADDR_W-1:0] LINE_WORDS = ADDR_W'(H_ACTIVE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [9:0]      last_y_q;
    logic [9:0]      t_q, t_d;
    logic [XW-1:0]   x_cnt_q, x_cnt_d;
    logic            vs_q;
    logic            front_q;
    logic            underrun_q, underrun_d;
    logic            underrun_set;
    logic            vis_q;
    logic [23:0]     rd_q;
    logic            trigger;
    logic [9:0]      trig_t;
    logic            wr_en;
    logic            visible;

    logic [23:0]     line_buf [2][H_ACTIVE];

    // A new DRAW_Y value starts a fetch of the next visible line, or of line 0 on the last line of the frame
    always_comb begin
        trigger = 1'b0;
        trig_t  = '0;
        if (DRAW_Y != last_y_q) begin
            if (({1'b0, DRAW_Y} + 11'd1) < {1'b0, V_ACT_10}) begin
                trigger = 1'b1;
                trig_t  = DRAW_Y + 10'd1;
            end else if (DRAW_Y == V_LAST_10) begin
                trigger = 1'b1;
                trig_t  = '0;
            end
        end
    end

    // Fetch sequencer: a retrigger mid-fetch abandons the line, flags underrun and restarts at x=0
    always_comb begin
        state_d      = state_q;
        t_d          = t_q;
        x_cnt_d      = x_cnt_q;
        underrun_set = 1'b0;
        wr_en        = 1'b0;
        MEM_REQ      = 1'b0;
        LINE_DONE    = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    t_d     = trig_t;
                    x_cnt_d = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                MEM_REQ = 1'b1;
                if (MEM_ACK) begin
                    wr_en   = 1'b1;
                    x_cnt_d = x_cnt_q + XW'(1);
                    if (x_cnt_q == X_LAST) begin
                        state_d = DONE;
                    end
                end
                if (trigger) begin
                    underrun_set = 1'b1;
                    t_d          = trig_t;
                    x_cnt_d      = '0;
                    state_d      = FETCH;
                end
            end
            DONE: begin
                LINE_DONE = 1'b1;
                state_d   = IDLE;
                if (trigger) begin
                    t_d     = trig_t;
                    x_cnt_d = '0;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request address is only driven while fetching so it reads zero when idle or in reset
    always_comb begin
        MEM_ADDR = '0;
        if (state_q == FETCH) begin
            MEM_ADDR = (front_q ? BASE1 : BASE0)
                     + ADDR_W'(t_q) * LINE_WORDS
                     + ADDR_W'(x_cnt_q);
        end
    end

    // Underrun is sticky; a new underrun beats a simultaneous clear
    always_comb begin
        underrun_d = underrun_q;
        if (underrun_set) begin
            underrun_d = 1'b1;
        end else if (CLR_UNDERRUN) begin
            underrun_d = 1'b0;
        end
    end

    assign visible = (DRAW_X < H_ACT_10) && (DRAW_Y < V_ACT_10);

    // Control state, line tracking, vsync edge detect and front-buffer selection
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            t_q        <= '0;
            x_cnt_q    <= '0;
            last_y_q   <= 10'h3FF;
            vs_q       <= 1'b1;
            front_q    <= 1'b0;
            underrun_q <= 1'b0;
            vis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            x_cnt_q    <= x_cnt_d;
            last_y_q   <= DRAW_Y;
            vs_q       <= VGA_VS;
            underrun_q <= underrun_d;
            vis_q      <= visible;
            if (vs_q && !VGA_VS) begin
                front_q <= FB_SEL;
            end
        end
    end

    // Line buffer write port, fed by accepted memory words
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            line_buf[t_q[0]][x_cnt_q] <= MEM_RDATA;
        end
    end

    // Line buffer read port for the raster; blanking is masked by the registered visible flag
    always_ff @(posedge CLK) begin
        if (visible) begin
            rd_q <= line_buf[DRAW_Y[0]][XW'(DRAW_X)];
        end
    end

    assign {PIX_B, PIX_G, PIX_R} = vis_q ? rd_q : 24'd0;
    assign FRONT_BUF             = front_q;
    assign UNDERRUN              = underrun_q;

endmodule

// File: tb/tb_vga_line_prefetcher.sv
// Directed-plus-random bench for vga_line_prefetcher with a frame-buffer
// memory model and a per-buffer picture of what each line buffer should hold.
module tb_vga_line_prefetcher;

    localparam int H     = 640;
    localparam int V_ACT = 480;
    localparam int V_TOT = 525;
    localparam int FB1   = 307200;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [9:0]  DRAW_X;
    logic [9:0]  DRAW_Y;
    logic        VGA_VS;
    logic        FB_SEL;
    logic        CLR_UNDERRUN;
    logic        MEM_REQ;
    logic [19:0] MEM_ADDR;
    logic        MEM_ACK;
    logic [23:0] MEM_RDATA;
    logic [7:0]  PIX_R, PIX_G, PIX_B;
    logic        FRONT_BUF;
    logic        LINE_DONE;
    logic        UNDERRUN;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] seed;
    logic [23:0] modelBuf [2][H];
    bit          known [2][H];
    bit          modelFront;
    logic [23:0] pixExp;
    bit          pixExpValid;

    vga_line_prefetcher dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .DRAW_X       (DRAW_X),
        .DRAW_Y       (DRAW_Y),
        .VGA_VS       (VGA_VS),
        .FB_SEL       (FB_SEL),
        .CLR_UNDERRUN (CLR_UNDERRUN),
        .MEM_REQ      (MEM_REQ),
        .MEM_ADDR     (MEM_ADDR),
        .MEM_ACK      (MEM_ACK),
        .MEM_RDATA    (MEM_RDATA),
        .PIX_R        (PIX_R),
        .PIX_G        (PIX_G),
        .PIX_B        (PIX_B),
        .FRONT_BUF    (FRONT_BUF),
        .LINE_DONE    (LINE_DONE),
        .UNDERRUN     (UNDERRUN)
    );

    always #5 CLK = ~CLK;

    // Hard stop in case the design never finishes a fetch
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no completion, expected completion before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Frame-buffer contents: a scrambled function of the word address
    function automatic logic [23:0] memWord(input logic [19:0] a);
        logic [31:0] h;
        h = ({12'd0, a} * 32'h9E3779B1) ^ seed;
        return h[23:0];
    endfunction

    function automatic logic [19:0] expAddr(input int t, input int k);
        int a;
        a = (modelFront ? FB1 : 0) + t * H + k;
        return a[19:0];
    endfunction

    function automatic int targetOf(input int y);
        if (y + 1 < V_ACT) return y + 1;
        if (y == V_TOT - 1) return 0;
        return -1;
    endfunction

    // Drive raster position and predict the pixel that appears one cycle later
    task automatic applyStimulus(input int x, input int y);
        DRAW_X = 10'(x);
        DRAW_Y = 10'(y);
        if (x < H && y < V_ACT) begin
            pixExpValid = known[y % 2][x];
            pixExp      = modelBuf[y % 2][x];
        end else begin
            pixExpValid = 1'b1;
            pixExp      = 24'd0;
        end
    endtask

    // Serve a fetch already in progress at x=0 until all words are accepted
    task automatic finishFetch(input int t, input int mode);
        int          k, cyc, addrBad, pixBad;
        bit          ack;
        logic [19:0] ea;
        k = 0; cyc = 0; addrBad = 0; pixBad = 0;
        while (k < H && cyc < H * 6) begin
            ea = expAddr(t, k);
            if (MEM_REQ !== 1'b1 || MEM_ADDR !== ea || LINE_DONE !== 1'b0) addrBad++;
            if (pixExpValid && {PIX_B, PIX_G, PIX_R} !== pixExp) pixBad++;
            case (mode)
                0:       ack = 1'b1;
                1:       ack = (cyc % 4 == 3);
                default: ack = ($urandom_range(0, 2) != 0);
            endcase
            MEM_ACK   = ack;
            MEM_RDATA = ack ? memWord(ea) : 24'($urandom);
            applyStimulus(int'($urandom_range(0, 799)), int'(DRAW_Y));
            tick();
            if (ack) begin
                modelBuf[t % 2][k] = memWord(ea);
                known[t % 2][k]    = 1'b1;
                k++;
            end
            cyc++;
        end
        MEM_ACK = 1'b0;
        checkOutput("fetch_ack_count", k, H);
        if (mode == 0) checkOutput("fullspeed_cycles", cyc, H);
        checkOutput("addr_sequence_bad_cycles", addrBad, 0);
        checkOutput("pixel_bad_cycles", pixBad, 0);
        checkOutput("line_done_pulse", LINE_DONE, 1);
        checkOutput("req_drop_after_last_ack", MEM_REQ, 0);
        if (pixExpValid) checkOutput("pixel_at_done", {PIX_B, PIX_G, PIX_R}, pixExp);
        tick();
        checkOutput("line_done_one_cycle", LINE_DONE, 0);
        checkOutput("req_idle_after_done", MEM_REQ, 0);
    endtask

    // Move to line y from idle and run the whole resulting fetch
    task automatic runFetch(input int y, input int x0, input int mode);
        int t;
        t = targetOf(y);
        applyStimulus(x0, y);
        MEM_ACK = 1'b0;
        tick();
        checkOutput("req_after_trigger", MEM_REQ, 1);
        checkOutput("first_addr", MEM_ADDR, expAddr(t, 0));
        if (pixExpValid) checkOutput("pixel_one_cycle_later", {PIX_B, PIX_G, PIX_R}, pixExp);
        finishFetch(t, mode);
    endtask

    initial begin
        seed         = $urandom;
        modelFront   = 1'b0;
        pixExpValid  = 1'b0;
        pixExp       = 24'd0;
        RESET_N      = 1'b0;
        MEM_ACK      = 1'b1;
        MEM_RDATA    = 24'h0;
        DRAW_X       = 10'd0;
        DRAW_Y       = 10'd7;
        VGA_VS       = 1'b1;
        FB_SEL       = 1'b0;
        CLR_UNDERRUN = 1'b0;

        // Reset held with ACK high and a visible line present
        repeat (3) tick();
        checkOutput("reset_mem_req", MEM_REQ, 0);
        checkOutput("reset_mem_addr", MEM_ADDR, 0);
        checkOutput("reset_pix", {PIX_B, PIX_G, PIX_R}, 0);
        checkOutput("reset_front_buf", FRONT_BUF, 0);
        checkOutput("reset_line_done", LINE_DONE, 0);
        checkOutput("reset_underrun", UNDERRUN, 0);

        // Release: line 7 still present, so line 8 is fetched
        RESET_N = 1'b1;
        runFetch(7, 700, 2);
        // Full-speed line 6 fetch, then wait-stated line 7 with a line-6 pixel check
        runFetch(5, 10, 0);
        runFetch(6, 3, 1);
        runFetch(7, 100, 2);

        // CPU asks for buffer 1 mid-frame; nothing changes until vsync
        FB_SEL = 1'b1;
        runFetch(100, 5, 2);
        checkOutput("front_before_vs", FRONT_BUF, 0);

        // Blanking row gives black and no fetch
        applyStimulus(5, 500);
        tick();
        checkOutput("blank_row_pix", {PIX_B, PIX_G, PIX_R}, 0);
        checkOutput("no_fetch_in_blank", MEM_REQ, 0);

        // Vsync falls: front buffer takes FB_SEL
        VGA_VS     = 1'b0;
        modelFront = FB_SEL;
        applyStimulus(5, 490);
        tick();
        checkOutput("front_after_vs_fall", FRONT_BUF, modelFront);
        VGA_VS = 1'b1;
        FB_SEL = 1'b0;
        tick();
        checkOutput("front_holds_without_vs_fall", FRONT_BUF, modelFront);

        // Last line of frame fetches line 0 from the new base, then line 0 is displayed
        runFetch(524, 20, 0);
        runFetch(0, 9, 2);

        // Underrun: partial fetch of line 11, stalled, then DRAW_Y moves on
        applyStimulus(0, 10);
        MEM_ACK = 1'b0;
        tick();
        checkOutput("underrun_fetch_start", MEM_ADDR, expAddr(11, 0));
        for (int i = 0; i < 3; i++) begin
            MEM_ACK   = 1'b1;
            MEM_RDATA = memWord(expAddr(11, i));
            tick();
            modelBuf[1][i] = memWord(expAddr(11, i));
            known[1][i]    = 1'b1;
        end
        MEM_ACK = 1'b0;
        tick();
        tick();
        checkOutput("addr_hold_no_ack", MEM_ADDR, expAddr(11, 3));
        MEM_ACK   = 1'b1;
        MEM_RDATA = memWord(expAddr(11, 3));
        applyStimulus(1, 11);
        tick();
        modelBuf[1][3] = memWord(expAddr(11, 3));
        known[1][3]    = 1'b1;
        MEM_ACK        = 1'b0;
        checkOutput("underrun_set", UNDERRUN, 1);
        checkOutput("restart_req", MEM_REQ, 1);
        checkOutput("restart_addr", MEM_ADDR, expAddr(12, 0));
        checkOutput("no_done_for_abandoned", LINE_DONE, 0);
        checkOutput("partial_line_pixel", {PIX_B, PIX_G, PIX_R}, pixExp);
        applyStimulus(3, 11);
        tick();
        checkOutput("retrigger_ack_written", {PIX_B, PIX_G, PIX_R}, pixExp);
        checkOutput("restart_addr_held", MEM_ADDR, expAddr(12, 0));
        finishFetch(12, 0);
        checkOutput("underrun_sticky", UNDERRUN, 1);

        // Clear pulse
        CLR_UNDERRUN = 1'b1;
        tick();
        CLR_UNDERRUN = 1'b0;
        checkOutput("underrun_cleared", UNDERRUN, 0);

        // New underrun together with a clear: set wins
        applyStimulus(0, 20);
        tick();
        tick();
        applyStimulus(0, 21);
        CLR_UNDERRUN = 1'b1;
        tick();
        CLR_UNDERRUN = 1'b0;
        checkOutput("set_beats_clear", UNDERRUN, 1);
        checkOutput("restart_addr_2", MEM_ADDR, expAddr(22, 0));
        finishFetch(22, 2);

        // Reset asserted mid-fetch drops the request without waiting for a clock
        applyStimulus(0, 30);
        tick();
        checkOutput("req_before_async_reset", MEM_REQ, 1);
        RESET_N = 1'b0;
        #1;
        checkOutput("async_reset_req", MEM_REQ, 0);
        checkOutput("async_reset_addr", MEM_ADDR, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
